input_vc_buffer: RTL and testbench

- Router input stage, directly upstream of output_module.
- Accepts one 37-bit link flit per cycle and sorts it into one of N_VC per-VC FIFOs.
- Presents each VC's head flit, with an XY-routed one-hot output-port select, to the output stage.
- Tracks wormhole packet state per VC so the route is held from head flit through tail flit.

---
 rtl/noc_pkg.sv | 33 +++
 rtl/vc_fifo.sv | 42 ++++
 rtl/input_vc_buffer.sv | 127 ++++++++++++
 tb/tb_input_vc_buffer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: link/flit widths, flit field offsets, route codes, packet FSM states.
package noc_pkg;

    localparam int unsigned FlitW      = 34;
    localparam int unsigned LinkW      = 37;
    localparam int unsigned NVcDefault = 3;
    localparam int unsigned RouteW     = 5;

    // Field offsets inside the 34-bit flit
    localparam int unsigned TypeLsb  = 32;
    localparam int unsigned XDestBit = 31;
    localparam int unsigned YDestBit = 30;
    localparam int unsigned SizeLsb  = 22;
    localparam int unsigned SizeW    = 8;

    typedef enum logic [1:0] {
        HEAD = 2'b00,
        BODY = 2'b01,
        TAIL = 2'b10
    } flit_type_e;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_e;

    localparam logic [RouteW-1:0] RouteLocal = 5'b00001;
    localparam logic [RouteW-1:0] RouteNorth = 5'b00010;
    localparam logic [RouteW-1:0] RouteSouth = 5'b00100;
    localparam logic [RouteW-1:0] RouteEast  = 5'b01000;
    localparam logic [RouteW-1:0] RouteWest  = 5'b10000;

endpackage

// File: rtl/vc_fifo.sv
// Single-VC flit FIFO: registered write, combinational read of the head entry.
module vc_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Extra MSB distinguishes full from empty when the index bits match
    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    // Pointer update with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && !full_o) wptr_q <= wptr_q + 1'b1;
            if (pop_i && !empty_o) rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/input_vc_buffer.sv
// Router input stage: per-VC FIFOs, XY route select and wormhole packet tracking.
module input_vc_buffer
    import noc_pkg::*;
#(
    parameter int unsigned N_VC       = NVcDefault,
    parameter int unsigned BUFF_DEPTH = 4,
    parameter logic        ROUTER_X   = 1'b0,
    parameter logic        ROUTER_Y   = 1'b0
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [LinkW-1:0]         fin_req_i,
    output logic [N_VC-1:0]          fin_resp_o,
    output logic [N_VC*LinkW-1:0]    fout_req_o,
    output logic [N_VC*RouteW-1:0]   fout_route_o,
    input  logic [N_VC-1:0]          fout_resp_i,
    output logic [N_VC-1:0]          err_o
);

    logic [N_VC-1:0]   push, pop, full, empty;
    logic [FlitW-1:0]  head [N_VC];

    pkt_state_e        state_q [N_VC];
    pkt_state_e        state_d [N_VC];
    logic [RouteW-1:0] route_q [N_VC];
    logic [RouteW-1:0] route_d [N_VC];
    logic [N_VC-1:0]   err_q, err_d;

    function automatic logic [RouteW-1:0] xy_route(input logic x, input logic y);
        logic east, west, south, north;
        east  = x & ~ROUTER_X;
        west  = ~x & ROUTER_X;
        south = y & ~ROUTER_Y;
        north = ~y & ROUTER_Y;
        if (east)       return RouteEast;
        else if (west)  return RouteWest;
        else if (south) return RouteSouth;
        else if (north) return RouteNorth;
        else            return RouteLocal;
    endfunction

    for (genvar v = 0; v < N_VC; v++) begin : g_vc
        // vc_id values with no matching FIFO never push and are dropped
        assign push[v] = fin_req_i[0] && (fin_req_i[2:1] == 2'(v)) && !full[v];
        assign pop[v]  = arst && !empty[v] && fout_resp_i[v];

        vc_fifo #(
            .WIDTH (FlitW),
            .DEPTH (BUFF_DEPTH)
        ) u_fifo (
            .clk_i   (clk),
            .rst_ni  (arst),
            .push_i  (push[v]),
            .pop_i   (pop[v]),
            .data_i  (fin_req_i[LinkW-1:3]),
            .data_o  (head[v]),
            .full_o  (full[v]),
            .empty_o (empty[v])
        );
    end

    // Packet FSM next state, route latch and sticky error, evaluated on each pop
    always_comb begin
        err_d = err_q;
        for (int v = 0; v < N_VC; v++) begin
            state_d[v] = state_q[v];
            route_d[v] = route_q[v];
            if (pop[v]) begin
                case (head[v][TypeLsb +: 2])
                    HEAD: begin
                        if (state_q[v] == IN_PKT) err_d[v] = 1'b1;
                        // A head mid-packet restarts the packet from this head
                        if (head[v][SizeLsb +: SizeW] != '0) begin
                            state_d[v] = IN_PKT;
                            route_d[v] = xy_route(head[v][XDestBit], head[v][YDestBit]);
                        end else begin
                            state_d[v] = IDLE;
                        end
                    end
                    BODY: begin
                        if (state_q[v] == IDLE) err_d[v] = 1'b1;
                    end
                    TAIL: begin
                        if (state_q[v] == IDLE) err_d[v] = 1'b1;
                        state_d[v] = IDLE;
                    end
                    default: err_d[v] = 1'b1;
                endcase
            end
        end
    end

    // Packet state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!arst) begin
            err_q <= '0;
            for (int v = 0; v < N_VC; v++) begin
                state_q[v] <= IDLE;
                route_q[v] <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int v = 0; v < N_VC; v++) begin
                state_q[v] <= state_d[v];
                route_q[v] <= route_d[v];
            end
        end
    end

    // Link-side ready and output-stage head flit/route presentation
    always_comb begin
        fin_resp_o   = '0;
        fout_req_o   = '0;
        fout_route_o = '0;
        for (int v = 0; v < N_VC; v++) begin
            fin_resp_o[v] = arst && !full[v];
            if (arst && !empty[v]) begin
                fout_req_o[v*LinkW +: LinkW] = {head[v], 2'(v), 1'b1};
                fout_route_o[v*RouteW +: RouteW] = (state_q[v] == IN_PKT) ? route_q[v] :
                    xy_route(head[v][XDestBit], head[v][YDestBit]);
            end
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_input_vc_buffer.sv
// Scoreboard bench for input_vc_buffer: stimulus queues expected pops, a monitor checks them.
module tb_input_vc_buffer;

    typedef struct packed {
        logic [36:0] req;
        logic [4:0]  route;
    } exp_t;

    logic          clk;
    logic          arst;
    logic [36:0]   fin_req_i;
    logic [2:0]    fin_resp_o;
    logic [110:0]  fout_req_o;
    logic [14:0]   fout_route_o;
    logic [2:0]    fout_resp_i;
    logic [2:0]    err_o;

    int total = 0;
    int bad   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    input_vc_buffer #(
        .N_VC       (3),
        .BUFF_DEPTH (4),
        .ROUTER_X   (1'b0),
        .ROUTER_Y   (1'b0)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .fin_req_i    (fin_req_i),
        .fin_resp_o   (fin_resp_o),
        .fout_req_o   (fout_req_o),
        .fout_route_o (fout_route_o),
        .fout_resp_i  (fout_resp_i),
        .err_o        (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(string name, logic [127:0] act, logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    function automatic logic [33:0] mk_head(logic x, logic y, logic [7:0] sz, logic [21:0] pl);
        return {2'b00, x, y, sz, pl};
    endfunction

    function automatic logic [36:0] lnk(logic [33:0] f, logic [1:0] vc);
        return {f, vc, 1'b1};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pop(int vc, logic [36:0] r, logic [4:0] rt);
        exp_t e;
        e.req   = r;
        e.route = rt;
        case (vc)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Offer one flit for one cycle; queue its expected pop when it should be accepted
    task automatic send(int vc, logic [33:0] f, bit accept, logic [4:0] rt);
        fin_req_i = lnk(f, 2'(vc));
        if (accept) expect_pop(vc, fin_req_i, rt);
        cyc();
        fin_req_i = '0;
    endtask

    // Monitor: compare every popped head flit and route against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        bit   got;
        if (arst) begin
            for (int v = 0; v < 3; v++) begin
                if (fout_req_o[v*37] && fout_resp_i[v]) begin
                    got = 1'b0;
                    e   = '0;
                    case (v)
                        0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                        1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                        default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                    endcase
                    if (!got) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pop vc%0d: got %h expected none", v,
                                 fout_req_o[v*37 +: 37]);
                    end else begin
                        check($sformatf("pop_vc%0d", v),
                              {86'b0, fout_route_o[v*5 +: 5], fout_req_o[v*37 +: 37]},
                              {86'b0, e.route, e.req});
                    end
                end
            end
        end
    end

    logic [33:0] f;

    initial begin
        arst        = 1'b0;
        fin_req_i   = '0;
        fout_resp_i = '0;

        // Reset held for four cycles
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("rst_fin_resp", {125'b0, fin_resp_o}, 128'h0);
            check("rst_fout_req", {17'b0, fout_req_o}, 128'h0);
            check("rst_err", {125'b0, err_o}, 128'h0);
        end
        arst = 1'b1;
        cyc();
        check("release_fin_resp", {125'b0, fin_resp_o}, 128'h7);

        // Single-flit packet on VC1, East
        f = mk_head(1'b1, 1'b0, 8'd0, 22'h0A5A5);
        send(1, f, 1'b1, 5'b01000);
        check("single_slice_lo", {125'b0, fout_req_o[37 +: 3]}, 128'h3);
        check("single_route", {123'b0, fout_route_o[9:5]}, 128'h08);
        fout_resp_i = 3'b010;
        cyc();
        fout_resp_i = 3'b000;
        check("single_empty", {91'b0, fout_req_o[37 +: 37]}, 128'h0);
        check("single_route_zero", {123'b0, fout_route_o[9:5]}, 128'h0);

        // Wormhole on VC0: body/tail carry misleading bits 31:30
        send(0, mk_head(1'b0, 1'b1, 8'd2, 22'h00111), 1'b1, 5'b00100);
        send(0, {2'b01, 2'b10, 30'h0000222}, 1'b1, 5'b00100);
        send(0, {2'b10, 2'b11, 30'h0000333}, 1'b1, 5'b00100);
        check("worm_head_route", {123'b0, fout_route_o[4:0]}, 128'h04);
        check("worm_fin_resp", {125'b0, fin_resp_o}, 128'h7);
        fout_resp_i = 3'b001;
        repeat (3) cyc();
        fout_resp_i = 3'b000;
        check("worm_empty", {91'b0, fout_req_o[36:0]}, 128'h0);
        check("worm_route_zero", {123'b0, fout_route_o[4:0]}, 128'h0);

        // Full / backpressure on VC2
        for (int i = 0; i < 4; i++) begin
            send(2, mk_head(1'b0, 1'b0, 8'd0, 22'(32'h100 + i)), 1'b1, 5'b00001);
        end
        check("full_fin_resp", {125'b0, fin_resp_o}, 128'h3);
        send(2, mk_head(1'b0, 1'b0, 8'd0, 22'h1F5), 1'b0, 5'b00001);
        check("full_after_drop", {125'b0, fin_resp_o}, 128'h3);
        fout_resp_i = 3'b100;
        send(2, mk_head(1'b0, 1'b0, 8'd0, 22'h1F6), 1'b0, 5'b00001);
        repeat (3) cyc();
        fout_resp_i = 3'b000;
        check("full_drained", {91'b0, fout_req_o[74 +: 37]}, 128'h0);

        // Interleaved VC0 / VC2 with continuous pops, plus an illegal vc_id
        fout_resp_i = 3'b101;
        send(0, mk_head(1'b1, 1'b0, 8'd0, 22'h200), 1'b1, 5'b01000);
        send(2, mk_head(1'b0, 1'b1, 8'd0, 22'h201), 1'b1, 5'b00100);
        fin_req_i = lnk(mk_head(1'b0, 1'b0, 8'd0, 22'h2FF), 2'b11);
        check("vc3_fin_resp", {125'b0, fin_resp_o}, 128'h7);
        cyc();
        fin_req_i = '0;
        send(0, mk_head(1'b0, 1'b0, 8'd0, 22'h202), 1'b1, 5'b00001);
        send(2, mk_head(1'b1, 1'b1, 8'd0, 22'h203), 1'b1, 5'b01000);
        repeat (2) cyc();
        fout_resp_i = 3'b000;
        check("inter_all_empty", {17'b0, fout_req_o}, 128'h0);
        check("inter_err", {125'b0, err_o}, 128'h0);

        // Protocol error: body popped on idle VC1
        send(1, {2'b01, 2'b00, 30'h0000444}, 1'b1, 5'b00001);
        fout_resp_i = 3'b010;
        cyc();
        fout_resp_i = 3'b000;
        check("err_set", {125'b0, err_o}, 128'h2);
        cyc();
        check("err_sticky", {125'b0, err_o}, 128'h2);
        arst = 1'b0;
        cyc();
        check("err_cleared", {125'b0, err_o}, 128'h0);
        check("rst_again_fin_resp", {125'b0, fin_resp_o}, 128'h0);
        arst = 1'b1;
        cyc();
        check("release_again", {125'b0, fin_resp_o}, 128'h7);

        check("sb_vc0_drained", 128'(q0.size()), 128'h0);
        check("sb_vc1_drained", 128'(q1.size()), 128'h0);
        check("sb_vc2_drained", 128'(q2.size()), 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
